if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch (IF) stage; sits directly upstream of the ID stage and the hazard/flush controller.
- Drives the SRAM-like instruction port and holds the current PC.
- Hands {pc, inst, adef} to ID with a valid/allow_in handshake.
- Applies branch and flush redirects and discards stale in-flight responses. This discard is the cancel mechanism, owned here rather than in the hazard logic.

Parameters:
RESET_PC  32'h1c000000  PC fetched first after reset
ADDR_W    32            PC / address width

Ports:
aclk           in   1       clock
reset          in   1       synchronous, active-high reset
inst_req       out  1       fetch request
inst_addr      out  ADDR_W  fetch address; stable while inst_req=1 and inst_addr_ok=0
inst_addr_ok   in   1       request accepted this cycle
inst_data_ok   in   1       response valid this cycle
inst_rdata     in   32      response instruction
id_allow_in    in   1       ID can accept this cycle
br_taken       in   1       ID-stage redirect (pcsel==PC_BRANCH, ID advancing)
br_target      in   ADDR_W  branch target
flush          in   1       exception/ertn/idle redirect; priority over br_taken
flush_pc       in   ADDR_W  flush target
if_valid_out   out  1       {if_pc, if_inst, if_adef} valid; equals if_ready_go
if_pc          out  ADDR_W  PC of offered instruction
if_inst        out  32      offered instruction (0 when if_adef)
if_adef        out  1       PC misaligned (pc[1:0]!=0); no memory request was issued

Behaviour:
- Clock and reset: one clock, aclk. Reset is synchronous and active-high on `reset`.
- Reset values: inst_req=0, if_valid_out=0, if_adef=0, if_inst=0, if_pc=RESET_PC, drop=0, state=REQ. The first request (addr=RESET_PC) is presented the cycle after reset deasserts.
- Reset mid-operation: all state is discarded, including a pending drop. An inst_data_ok arriving after reset belongs to the pre-reset request and is ignored.
- States:
  - REQ: inst_req=1, inst_addr=pc.
  - WAIT: one outstanding request; inst_req=0.
  - HOLD: response buffered; waiting for ID.
  - ERR: misaligned PC; no request.
- REQ transitions:
  - Entered with pc[1:0]!=0 → ERR, inst_req stays 0.
  - inst_addr_ok=1 → WAIT.
  - A redirect while in REQ (accepted or not) does not alter inst_addr. It latches tgt and sets drop=1, applied once the request is accepted.
- WAIT, on inst_data_ok:
  - drop=1 → discard the data, pc<=tgt, drop<=0 → REQ.
  - Redirect in the same cycle → discard the data, pc<=new target → REQ.
  - Otherwise the data is offered combinationally: if_valid_out=1, if_inst=inst_rdata.
    - With id_allow_in=1: transfer, pc<=pc+4 → REQ.
    - With id_allow_in=0: buffer the instruction → HOLD.
- WAIT, redirect without inst_data_ok: drop<=1, tgt<=target.
- HOLD: if_valid_out=1 from the buffer.
  - Transfer: pc<=pc+4 → REQ.
  - Redirect: clear the buffer, pc<=target → REQ.
- ERR: if_valid_out=1, if_adef=1, if_inst=0.
  - Transfer: pc<=pc+4 → REQ.
  - Redirect: pc<=target → REQ.
- Transfer condition: if_valid_out && id_allow_in && !br_taken && !flush. A redirect in the same cycle kills the offered instruction.
- Redirect priority: flush > br_taken. A later redirect while drop=1 overwrites tgt; drop stays 1.
- At most one outstanding request. inst_req is never asserted in WAIT, HOLD or ERR.
- PC arithmetic: pc+4 wraps modulo 2^ADDR_W.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds outputs perf_stall_cyc[31:0] and perf_drop_cnt[31:0].
  - perf_stall_cyc increments each cycle in REQ or WAIT with no valid output.
  - perf_drop_cnt increments per discarded response.
  - Both counters clear on reset and wrap at 2^32.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset sequence, with addr_ok=1 and data_ok one cycle later (rdata=0x02800000), id_allow_in=1:
  - reset held 3 cycles, then released.
  - Required: inst_req=1 and inst_addr=0x1c000000 the cycle after release.
  - Required: if_pc=0x1c000000, if_inst=0x02800000 offered; next request addr=0x1c000004.
- Back-pressure: id_allow_in=0 for 4 cycles when data_ok arrives with rdata=0x12345678.
  - Required: HOLD, if_valid_out held at 1 with if_inst=0x12345678.
  - Required: no inst_req until id_allow_in rises; then request addr=pc+4.
- Branch while WAIT: br_taken=1, br_target=0x1c000100 two cycles before data_ok.
  - Required: that response is dropped (if_valid_out stays 0).
  - Required: next inst_req addr=0x1c000100.
- Flush and branch in the same cycle as data_ok: flush_pc=0x1c008000, br_target=0x1c000200.
  - Required: the data is discarded and the next addr is 0x1c008000.
- Misaligned target: br_target=0x1c000102.
  - Required: no inst_req; if_valid_out=1, if_adef=1, if_inst=0, if_pc=0x1c000102.
  - Required: after transfer, next fetch addr=0x1c000106 (also misaligned → ERR again).
- Redirect while REQ with addr_ok held low 3 cycles:
  - Required: inst_addr stays stable at the old pc.
  - Required: after addr_ok, the response is dropped and the next fetch uses the redirect target.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: drives the SRAM-like instruction port, holds the PC,
// offers {pc, inst, adef} to ID and cancels stale responses after redirects.
// Optional build macro FETCH_PERF_CNT_EN adds stall / dropped-response counters.
module if_fetch_stage #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h1c000000
) (
  input  logic              aclk,
  input  logic              reset,
  output logic              inst_req,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_addr_ok,
  input  logic              inst_data_ok,
  input  logic [31:0]       inst_rdata,
  input  logic              id_allow_in,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  output logic              if_valid_out,
  output logic [ADDR_W-1:0] if_pc,
  output logic [31:0]       if_inst,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]       perf_stall_cyc,
  output logic [31:0]       perf_drop_cnt,
`endif
  output logic              if_adef
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_ERR} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic [ADDR_W-1:0] tgt, tgt_n;
  logic              drop, drop_n;
  logic [31:0]       buf_q, buf_n;

  logic              redirect;
  logic [ADDR_W-1:0] redir_pc;
  logic [ADDR_W-1:0] pc_inc;
  logic              discard;

  // A misaligned PC is resolved into ERR as soon as it is loaded, so REQ never
  // holds a misaligned address and no request is ever issued for one.
  function automatic state_t entry_state(input logic [ADDR_W-1:0] a);
    return (a[1:0] != 2'b00) ? S_ERR : S_REQ;
  endfunction

  assign redirect = flush | br_taken;
  assign redir_pc = flush ? flush_pc : br_target;
  assign pc_inc   = pc + ADDR_W'(4);
  assign discard  = (state == S_WAIT) && inst_data_ok && (drop || redirect);

  // Handshake outputs; inst_req is held off during reset so no request is
  // accepted whose response could later be mistaken for a fresh one.
  always_comb begin
    inst_req     = (state == S_REQ) && !reset;
    inst_addr    = pc;
    if_pc        = pc;
    if_adef      = (state == S_ERR);
    if_valid_out = 1'b0;
    if_inst      = '0;
    case (state)
      S_WAIT: begin
        if_valid_out = inst_data_ok && !drop;
        if (inst_data_ok && !drop) if_inst = inst_rdata;
      end
      S_HOLD: begin
        if_valid_out = 1'b1;
        if_inst      = buf_q;
      end
      S_ERR:   if_valid_out = 1'b1;
      default: ;
    endcase
  end

  // Next-state, PC, pending-drop and buffer update.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    tgt_n   = tgt;
    drop_n  = drop;
    buf_n   = buf_q;
    case (state)
      S_REQ: begin
        // inst_addr must stay stable until accepted; remember the redirect.
        if (redirect) begin
          tgt_n  = redir_pc;
          drop_n = 1'b1;
        end
        if (inst_addr_ok) state_n = S_WAIT;
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          if (drop || redirect) begin
            // A same-cycle redirect is newer than any latched target.
            pc_n    = redirect ? redir_pc : tgt;
            drop_n  = 1'b0;
            state_n = entry_state(pc_n);
          end else if (id_allow_in) begin
            pc_n    = pc_inc;
            state_n = entry_state(pc_n);
          end else begin
            buf_n   = inst_rdata;
            state_n = S_HOLD;
          end
        end else if (redirect) begin
          drop_n = 1'b1;
          tgt_n  = redir_pc;
        end
      end
      S_HOLD, S_ERR: begin
        if (redirect) begin
          pc_n    = redir_pc;
          buf_n   = '0;
          state_n = entry_state(pc_n);
        end else if (id_allow_in) begin
          pc_n    = pc_inc;
          state_n = entry_state(pc_n);
        end
      end
      default: state_n = entry_state(pc);
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge aclk) begin
    if (reset) begin
      state <= entry_state(RESET_PC);
      pc    <= RESET_PC;
      tgt   <= '0;
      drop  <= 1'b0;
      buf_q <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      tgt   <= tgt_n;
      drop  <= drop_n;
      buf_q <= buf_n;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Stall cycles (REQ/WAIT with nothing offered) and discarded responses.
  always_ff @(posedge aclk) begin
    if (reset) begin
      perf_stall_cyc <= '0;
      perf_drop_cnt  <= '0;
    end else begin
      if ((state == S_REQ || state == S_WAIT) && !if_valid_out)
        perf_stall_cyc <= perf_stall_cyc + 32'd1;
      if (discard)
        perf_drop_cnt <= perf_drop_cnt + 32'd1;
    end
  end
`else
  logic unused_discard;
  assign unused_discard = discard;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: expected ID transfers are queued as
// stimulus is driven and compared when the DUT hands an instruction to ID.
module tb_if_fetch_stage;

  logic        aclk;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        id_allow_in;
  logic        br_taken;
  logic [31:0] br_target;
  logic        flush;
  logic [31:0] flush_pc;
  logic        if_valid_out;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_adef;

  int checks = 0;
  int errors = 0;

  // {adef, pc, inst}
  logic [64:0] exp_q[$];

  if_fetch_stage #(.ADDR_W(32), .RESET_PC(32'h1c000000)) dut (
    .aclk(aclk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .id_allow_in(id_allow_in),
    .br_taken(br_taken), .br_target(br_target),
    .flush(flush), .flush_pc(flush_pc),
    .if_valid_out(if_valid_out), .if_pc(if_pc), .if_inst(if_inst), .if_adef(if_adef)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic push(input logic adef, input logic [31:0] pc, input logic [31:0] inst);
    exp_q.push_back({adef, pc, inst});
  endtask

  // Accept the request at exp_addr this cycle, advancing into WAIT.
  task automatic accept(input string tag, input logic [31:0] exp_addr);
    inst_addr_ok = 1'b1;
    settle();
    chk({tag, "_req"}, {31'd0, inst_req}, 32'd1);
    chk({tag, "_addr"}, inst_addr, exp_addr);
    cyc();
    inst_addr_ok = 1'b0;
  endtask

  // Compare every transfer into ID against the scoreboard.
  always @(negedge aclk) begin
    if (!reset && if_valid_out && id_allow_in && !br_taken && !flush) begin
      if (exp_q.size() == 0) begin
        checks++;
        assert (0) else begin
          errors++;
          $error("FAIL xfer_unexpected observed pc=%h inst=%h expected=none", if_pc, if_inst);
        end
      end else begin
        logic [64:0] e;
        e = exp_q.pop_front();
        chk("xfer_pc", if_pc, e[63:32]);
        chk("xfer_inst", if_inst, e[31:0]);
        chk("xfer_adef", {31'd0, if_adef}, {31'd0, e[64]});
      end
    end
  end

  initial begin
    reset = 1'b1; inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = '0;
    id_allow_in = 0; br_taken = 0; br_target = '0; flush = 0; flush_pc = '0;

    // Reset held three cycles.
    cyc();
    settle();
    chk("rst_req", {31'd0, inst_req}, 32'd0);
    chk("rst_valid", {31'd0, if_valid_out}, 32'd0);
    chk("rst_pc", if_pc, 32'h1c000000);
    chk("rst_inst", if_inst, 32'd0);
    chk("rst_adef", {31'd0, if_adef}, 32'd0);
    cyc(); cyc();
    reset = 1'b0;
    id_allow_in = 1'b1;

    // First fetch and transfer.
    accept("first", 32'h1c000000);
    inst_data_ok = 1'b1; inst_rdata = 32'h02800000;
    push(1'b0, 32'h1c000000, 32'h02800000);
    settle();
    chk("first_valid", {31'd0, if_valid_out}, 32'd1);
    cyc();
    inst_data_ok = 1'b0;

    // Back-pressure: response buffered while ID stalls.
    accept("bp", 32'h1c000004);
    id_allow_in = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h12345678;
    push(1'b0, 32'h1c000004, 32'h12345678);
    cyc();
    inst_data_ok = 1'b0; inst_rdata = 32'hffffffff;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("hold_valid", {31'd0, if_valid_out}, 32'd1);
      chk("hold_inst", if_inst, 32'h12345678);
      chk("hold_req", {31'd0, inst_req}, 32'd0);
      cyc();
    end
    id_allow_in = 1'b1;
    settle();
    chk("hold_rel_req", {31'd0, inst_req}, 32'd0);
    cyc();

    // Branch two cycles before the response arrives.
    accept("br", 32'h1c000008);
    br_taken = 1'b1; br_target = 32'h1c000100;
    settle();
    chk("br_valid0", {31'd0, if_valid_out}, 32'd0);
    cyc();
    br_taken = 1'b0;
    cyc();
    inst_data_ok = 1'b1; inst_rdata = 32'hdeadbeef;
    settle();
    chk("br_drop_valid", {31'd0, if_valid_out}, 32'd0);
    cyc();
    inst_data_ok = 1'b0;

    // Flush and branch together with the response: flush wins.
    accept("fl", 32'h1c000100);
    inst_data_ok = 1'b1; inst_rdata = 32'haaaa5555;
    flush = 1'b1; flush_pc = 32'h1c008000;
    br_taken = 1'b1; br_target = 32'h1c000200;
    cyc();
    inst_data_ok = 1'b0; flush = 1'b0; br_taken = 1'b0;

    // Misaligned branch target taken with the response.
    accept("mis_pre", 32'h1c008000);
    inst_data_ok = 1'b1; inst_rdata = 32'h11111111;
    br_taken = 1'b1; br_target = 32'h1c000102;
    cyc();
    inst_data_ok = 1'b0; br_taken = 1'b0;
    push(1'b1, 32'h1c000102, 32'h0);
    settle();
    chk("err_req", {31'd0, inst_req}, 32'd0);
    chk("err_valid", {31'd0, if_valid_out}, 32'd1);
    chk("err_adef", {31'd0, if_adef}, 32'd1);
    chk("err_inst", if_inst, 32'd0);
    chk("err_pc", if_pc, 32'h1c000102);
    cyc();
    br_taken = 1'b1; br_target = 32'h1c000300;
    settle();
    chk("err2_req", {31'd0, inst_req}, 32'd0);
    chk("err2_adef", {31'd0, if_adef}, 32'd1);
    chk("err2_pc", if_pc, 32'h1c000106);
    cyc();
    br_taken = 1'b0;

    // Redirect while the request waits for acceptance.
    br_taken = 1'b1; br_target = 32'h1c000400;
    settle();
    chk("rq_addr0", inst_addr, 32'h1c000300);
    cyc();
    br_taken = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("rq_addr_hold", inst_addr, 32'h1c000300);
      chk("rq_req_hold", {31'd0, inst_req}, 32'd1);
      cyc();
    end
    accept("rq", 32'h1c000300);
    inst_data_ok = 1'b1; inst_rdata = 32'hbad0bad0;
    settle();
    chk("rq_drop_valid", {31'd0, if_valid_out}, 32'd0);
    cyc();
    inst_data_ok = 1'b0;

    // Normal fetch at the redirect target.
    accept("tgt", 32'h1c000400);
    inst_data_ok = 1'b1; inst_rdata = 32'h0badf00d;
    push(1'b0, 32'h1c000400, 32'h0badf00d);
    cyc();
    inst_data_ok = 1'b0;
    settle();
    chk("seq_addr", inst_addr, 32'h1c000404);

    // Mid-operation reset returns to the reset PC.
    accept("pre_rst", 32'h1c000404);
    reset = 1'b1;
    cyc();
    settle();
    chk("rst2_pc", if_pc, 32'h1c000000);
    chk("rst2_req", {31'd0, inst_req}, 32'd0);
    reset = 1'b0;
    settle();
    chk("rst2_rel_req", {31'd0, inst_req}, 32'd1);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
